ftf_rx_03: RTL

Receive-side deframer for the 3-wire forbidden-transition-free (FTF) TSV link. It registers the TSV bundle and decodes each 3-bit codeword to its Fibonacci-numeral value 0..4. It flags codewords that violate the FTF rule and packs `SYMS` consecutive symbols into one output word. It sits at the far end of the TSV channel, opposite the clocked FTF encoder, and feeds the core-side consumer.

---
 rtl/ftf_rx_03_pkg.sv | 11 +
 rtl/ftf_rx_03_if.sv | 11 +
 rtl/ftf_rx_03_sym_dec.sv | 11 +
 rtl/ftf_rx_03.sv | 68 ++++++
 4 files changed

// File: rtl/ftf_rx_03_pkg.sv
// ftf_pkg: shared FTF 3-wire codeword constants and decode/validity helpers
package ftf_pkg;
  localparam int FTF03_W = 3;
  localparam int FTF03_NSYM = 5;
  function automatic logic ftf03_is_valid(input logic [2:0] t);
    return !((!t[0] && t[1]) || (t[1] && !t[2]));
  endfunction
  function automatic logic [2:0] ftf03_decode(input logic [2:0] t);
    return ftf03_is_valid(t) ? {2'b0, t[0]} + {2'b0, t[1]} + {t[2], 1'b0} : 3'd0;
  endfunction
endpackage

// File: rtl/ftf_rx_03_if.sv
// ftf_rx_03_if: TSV receive bundle and packed core-side word outputs
interface ftf_rx_03_if #(parameter int SYMS = 4, parameter int ERRW = 16);
  logic [2:0] tsv_in;
  logic tsv_valid;
  logic [3*SYMS-1:0] dataout;
  logic dataout_valid;
  logic word_err;
  logic [ERRW-1:0] err_count;
  modport master (output tsv_in, tsv_valid, input dataout, dataout_valid, word_err, err_count);
  modport slave (input tsv_in, tsv_valid, output dataout, dataout_valid, word_err, err_count);
endinterface

// File: rtl/ftf_rx_03_sym_dec.sv
// ftf_sym_dec_03: combinational FTF codeword to Fibonacci value decoder
module ftf_sym_dec_03
  import ftf_pkg::*;
(
  input  logic [2:0] tsv,
  output logic [2:0] value,
  output logic       invalid
);
  assign value = ftf03_decode(tsv);
  assign invalid = !ftf03_is_valid(tsv);
endmodule

// File: rtl/ftf_rx_03.sv
// ftf_rx_03: FTF TSV deframer capturing, decoding and packing SYMS symbols per word
module ftf_rx_03
  import ftf_pkg::*;
#(
  parameter int SYMS = 4,
  parameter int ERRW = 16
) (
  input logic clock,
  input logic reset,
  ftf_rx_03_if.slave bus
);
  localparam int CW = SYMS > 1 ? $clog2(SYMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SYMS - 1);
  logic [2:0] tsv_q, tsv_d, val;
  logic vld_q, vld_d, inv;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3*SYMS-1:0] asm_q, asm_d, dout_q, dout_d;
  logic asm_err_q, asm_err_d, werr_q, werr_d, dv_q, dv_d;
  logic [ERRW-1:0] ec_q, ec_d;
  ftf_sym_dec_03 u_dec (.tsv(tsv_q), .value(val), .invalid(inv));
  always_comb begin
    tsv_d = bus.tsv_in;
    vld_d = bus.tsv_valid;
    asm_d = asm_q;
    asm_err_d = asm_err_q;
    cnt_d = cnt_q;
    dout_d = dout_q;
    werr_d = werr_q;
    dv_d = 1'b0;
    ec_d = ec_q;
    if (vld_q) begin
      asm_d[int'(cnt_q)*3 +: 3] = val;
      ec_d = (inv && !(&ec_q)) ? ec_q + ERRW'(1) : ec_q;
      dv_d = cnt_q == LAST;
      dout_d = dv_d ? asm_d : dout_q;
      werr_d = dv_d ? asm_err_q | inv : werr_q;
      asm_err_d = dv_d ? 1'b0 : asm_err_q | inv;
      cnt_d = dv_d ? '0 : cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tsv_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
      asm_q <= '0;
      asm_err_q <= 1'b0;
      dout_q <= '0;
      werr_q <= 1'b0;
      dv_q <= 1'b0;
      ec_q <= '0;
    end else begin
      tsv_q <= tsv_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      asm_err_q <= asm_err_d;
      dout_q <= dout_d;
      werr_q <= werr_d;
      dv_q <= dv_d;
      ec_q <= ec_d;
    end
  end
  assign bus.dataout = dout_q;
  assign bus.dataout_valid = dv_q;
  assign bus.word_err = werr_q;
  assign bus.err_count = ec_q;
endmodule
